net_reflector: RTL



---
 rtl/net_reflector.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/net_reflector.sv
// net_reflector
//
// Network-side loopback endpoint for the NIC flit interface. Each complete
// frame transmitted on net_out is buffered and then replayed on net_in.
// A frame longer than the buffer is accepted in full, discarded, and
// counted in drop_count.
//
// Optional feature macro: NET_REFLECTOR_MAC_SWAP_EN
//   When this macro is defined, replayed frames are rewritten so the NIC
//   receives a frame addressed to itself:
//   - flit 0 [63:16] (destination MAC) takes stored flit 1 [47:0]
//     (source MAC), or 0 for a single-flit frame;
//   - flit 1 [47:0] takes MAC_ADDR.
//   When the macro is undefined, frames are replayed bit-exact.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the buffer depth in 64-bit flits
//   MAC_ADDR   - reflector MAC address, driven on net_macAddr
//
// Ports:
//   clock, reset          - single clock; synchronous active-high reset
//   net_out_valid/ready   - transmit flit handshake from the NIC
//   net_out_bits_data     - transmit flit data (64 bits)
//   net_out_bits_keep     - transmit byte enables (stored, not interpreted)
//   net_out_bits_last     - final flit of the transmitted frame
//   net_in_valid/ready    - receive flit handshake toward the NIC
//   net_in_bits_data      - replayed flit data (0 while not valid)
//   net_in_bits_keep      - replayed byte enables (0 while not valid)
//   net_in_bits_last      - final flit of the replayed frame
//   net_macAddr           - constant MAC_ADDR
//   drop_count            - saturating count of frames dropped for overflow
module net_reflector #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [47:0] MAC_ADDR   = 48'h020000000001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        net_out_valid,
  output logic        net_out_ready,
  input  logic [63:0] net_out_bits_data,
  input  logic [7:0]  net_out_bits_keep,
  input  logic        net_out_bits_last,
  output logic        net_in_valid,
  input  logic        net_in_ready,
  output logic [63:0] net_in_bits_data,
  output logic [7:0]  net_in_bits_keep,
  output logic        net_in_bits_last,
  output logic [47:0] net_macAddr,
  output logic [31:0] drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    RECV,
    SEND,
    DROP
  } state_t;

  state_t                state;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         len;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [31:0]           drop_cnt;
  // Low while reset is sampled high, so net_out_ready stays deasserted for
  // the whole reset window without a path from the reset pin to the output.
  logic                  live;

  // Frame buffer, split by field.
  logic [63:0] mem_data [DEPTH];
  logic [7:0]  mem_keep [DEPTH];
  logic        mem_last [DEPTH];

  logic        tx_fire;
  logic        rx_fire;
  logic        buf_full;
  logic        rd_final;
  logic        wr_en;
  logic [31:0] drop_next;

  // Handshake qualifiers are decoded from registers only.
  assign net_out_ready = live && (state != SEND);
  assign net_in_valid  = (state == SEND);

  assign tx_fire   = net_out_valid && net_out_ready;
  assign rx_fire   = net_in_valid && net_in_ready;
  assign buf_full  = (wr_cnt == DEPTH_C);
  assign rd_final  = ({1'b0, rd_ptr} == (len - CW'(1)));
  assign wr_en     = !reset && (state == RECV) && tx_fire && !buf_full;
  assign drop_next = (drop_cnt == '1) ? drop_cnt : drop_cnt + 32'd1;

  assign net_macAddr = MAC_ADDR;
  assign drop_count  = drop_cnt;

  // Control FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RECV;
      wr_cnt   <= '0;
      len      <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      live     <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        RECV: begin
          if (tx_fire) begin
            if (!buf_full) begin
              wr_cnt <= wr_cnt + CW'(1);
              if (net_out_bits_last) begin
                len    <= wr_cnt + CW'(1);
                rd_ptr <= '0;
                state  <= SEND;
              end
            end else if (net_out_bits_last) begin
              // Overflowing flit is itself the last one: nothing left to
              // discard, so the frame is dropped without visiting DROP.
              drop_cnt <= drop_next;
              wr_cnt   <= '0;
            end else begin
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (tx_fire && net_out_bits_last) begin
            drop_cnt <= drop_next;
            wr_cnt   <= '0;
            state    <= RECV;
          end
        end
        SEND: begin
          if (rx_fire) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (rd_final) begin
              wr_cnt <= '0;
              state  <= RECV;
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

  // Buffer write port; contents are never cleared.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_data[wr_cnt[DEPTH_LOG2-1:0]] <= net_out_bits_data;
      mem_keep[wr_cnt[DEPTH_LOG2-1:0]] <= net_out_bits_keep;
      mem_last[wr_cnt[DEPTH_LOG2-1:0]] <= net_out_bits_last;
    end
  end

  // Read path with optional MAC rewrite; outputs forced to zero when idle.
  logic [63:0] rd_data;

  always_comb begin
    rd_data = mem_data[rd_ptr];
`ifdef NET_REFLECTOR_MAC_SWAP_EN
    if (rd_ptr == '0) begin
      rd_data[63:16] = (len == CW'(1)) ? 48'h0 : mem_data[1][47:0];
    end else if (rd_ptr == DEPTH_LOG2'(1)) begin
      rd_data[47:0] = MAC_ADDR;
    end
`endif
    net_in_bits_data = '0;
    net_in_bits_keep = '0;
    net_in_bits_last = 1'b0;
    if (net_in_valid) begin
      net_in_bits_data = rd_data;
      net_in_bits_keep = mem_keep[rd_ptr];
      net_in_bits_last = rd_final || mem_last[rd_ptr];
    end
  end

endmodule
